// File: rtl/cpu_out_capture.sv
// CPU output capture: run/drain FSM gating the CPU output strobe into a FIFO.
// Optional saturating drop counter output ovf_count under CPU_OUT_CAPTURE_OVF_CNT_EN.
module cpu_out_capture #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  output logic                       startIO,
  input  logic                       outFlag,
  input  logic [WIDTH-1:0]           out,
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow
`ifdef CPU_OUT_CAPTURE_OVF_CNT_EN
  , output logic [15:0]              ovf_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             push, pop, drop;

  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));
  assign dout_valid = !empty;
  assign dout       = empty ? '0 : mem[rptr];

  always_comb begin
    pop  = dout_valid && dout_ready;
    push = outFlag && (state == RUN) && (!full || pop);
    drop = outFlag && (state == RUN) && full && !pop;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (!enable) state_nxt = DRAIN;
      DRAIN: begin
        // Re-enable wins over finishing the drain.
        if (enable)     state_nxt = RUN;
        else if (empty) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // startIO is a flop loaded with the next state's decode, so it tracks
  // state==RUN without any combinational path from enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      startIO <= 1'b0;
    end else begin
      state   <= state_nxt;
      startIO <= (state_nxt == RUN);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= out;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef CPU_OUT_CAPTURE_OVF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)                        ovf_count <= '0;
    else if (drop && ovf_count != '1) ovf_count <= ovf_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_cpu_out_capture.sv
// Self-checking bench for cpu_out_capture: vector table, directed corner
// sequences and a queue-based reference model checked after every edge.
module tb_cpu_out_capture;

  localparam int WIDTH = 36;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef enum {M_IDLE, M_RUN, M_DRAIN} mstate_t;

  typedef struct {
    bit               rst;
    bit               en;
    bit               flag;
    logic [WIDTH-1:0] word;
    bit               rdy;
    int               exp_count;
    bit               exp_start;
    logic [WIDTH-1:0] exp_dout;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset, enable, outFlag, dout_ready;
  logic [WIDTH-1:0] out, dout;
  logic             startIO, dout_valid, full, empty, overflow;
  logic [CW-1:0]    count;
`ifdef CPU_OUT_CAPTURE_OVF_CNT_EN
  logic [15:0]      ovf_count;
  int unsigned      m_ovf_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] drained[$];
  mstate_t          m_state;
  bit               m_ovf;
  vec_t             vecs[7];

  cpu_out_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .startIO    (startIO),
    .outFlag    (outFlag),
    .out        (out),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow)
`ifdef CPU_OUT_CAPTURE_OVF_CNT_EN
    , .ovf_count(ovf_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  function automatic void model_check();
    chk("count", 64'(count), 64'(q.size()));
    chk("empty", 64'(empty), 64'(q.size() == 0));
    chk("full", 64'(full), 64'(q.size() == DEPTH));
    chk("dout_valid", 64'(dout_valid), 64'(q.size() != 0));
    chk("dout", 64'(dout), (q.size() != 0) ? 64'(q[0]) : 64'h0);
    chk("startIO", 64'(startIO), 64'(m_state == M_RUN));
    chk("overflow", 64'(overflow), 64'(m_ovf));
`ifdef CPU_OUT_CAPTURE_OVF_CNT_EN
    chk("ovf_count", 64'(ovf_count), 64'(m_ovf_cnt));
`endif
  endfunction

  task automatic drive(bit r, bit e, bit f, logic [WIDTH-1:0] w, bit rd);
    reset = r; enable = e; outFlag = f; out = w; dout_ready = rd;
  endtask

  // One clock: model predicts from pre-edge inputs, DUT checked #1 after edge.
  task automatic step();
    bit mpop, mpush, mdrop, was_empty;
    was_empty = (q.size() == 0);
    mpop  = !was_empty && dout_ready;
    mpush = outFlag && (m_state == M_RUN) && ((q.size() < DEPTH) || mpop);
    mdrop = outFlag && (m_state == M_RUN) && (q.size() == DEPTH) && !mpop;
    @(posedge clk);
    if (reset) begin
      q.delete();
      m_state = M_IDLE;
      m_ovf   = 1'b0;
`ifdef CPU_OUT_CAPTURE_OVF_CNT_EN
      m_ovf_cnt = 0;
`endif
    end else begin
      if (mpop)  drained.push_back(q.pop_front());
      if (mpush) q.push_back(out);
      if (mdrop) begin
        m_ovf = 1'b1;
`ifdef CPU_OUT_CAPTURE_OVF_CNT_EN
        if (m_ovf_cnt < 32'hFFFF) m_ovf_cnt++;
`endif
      end
      case (m_state)
        M_IDLE:  if (enable) m_state = M_RUN;
        M_RUN:   if (!enable) m_state = M_DRAIN;
        default: begin
          if (enable)         m_state = M_RUN;
          else if (was_empty) m_state = M_IDLE;
        end
      endcase
    end
    #1;
    model_check();
  endtask

  task automatic reset_and_run();
    drive(1, 0, 0, '0, 0); step();
    drive(0, 1, 0, '0, 0); step();
    drained.delete();
  endtask

  task automatic fill(int n, int first);
    for (int i = 0; i < n; i++) begin
      drive(0, 1, 1, WIDTH'(first + i), 0);
      step();
    end
    drive(0, 1, 0, '0, 0);
  endtask

  initial begin
    m_state = M_IDLE;
    m_ovf   = 1'b0;
`ifdef CPU_OUT_CAPTURE_OVF_CNT_EN
    m_ovf_cnt = 0;
`endif
    vecs[0] = '{1, 0, 0, 36'h0,           0, 0, 0, 36'h0};
    vecs[1] = '{0, 1, 0, 36'h0,           0, 0, 1, 36'h0};
    vecs[2] = '{0, 1, 1, 36'h0_0000_0001, 1, 1, 1, 36'h0_0000_0001};
    vecs[3] = '{0, 1, 1, 36'h9_ABCD_1234, 1, 1, 1, 36'h9_ABCD_1234};
    vecs[4] = '{0, 1, 0, 36'h0,           1, 0, 1, 36'h0};
    vecs[5] = '{0, 0, 0, 36'h0,           1, 0, 0, 36'h0};
    vecs[6] = '{0, 0, 0, 36'h0,           1, 0, 0, 36'h0};

    drive(1, 0, 0, '0, 0);
    step();
    chk("reset_empty", 64'(empty), 64'h1);
    chk("reset_startIO", 64'(startIO), 64'h0);
    drained.delete();

    // Basic flow
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].flag, vecs[i].word, vecs[i].rdy);
      step();
      chk($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].exp_count));
      chk($sformatf("vec%0d_startIO", i), 64'(startIO), 64'(vecs[i].exp_start));
      chk($sformatf("vec%0d_dout", i), 64'(dout), 64'(vecs[i].exp_dout));
    end
    chk("basic_drained_n", 64'(drained.size()), 64'd2);
    if (drained.size() == 2) begin
      chk("basic_w0", 64'(drained[0]), 64'h0_0000_0001);
      chk("basic_w1", 64'(drained[1]), 64'h9_ABCD_1234);
    end

    // Overflow: ninth word dropped
    reset_and_run();
    fill(8, 1);
    chk("ovf_full", 64'(full), 64'h1);
    chk("ovf_pre", 64'(overflow), 64'h0);
    drive(0, 1, 1, WIDTH'(9), 0); step();
    chk("ovf_set", 64'(overflow), 64'h1);
    chk("ovf_count8", 64'(count), 64'd8);
`ifdef CPU_OUT_CAPTURE_OVF_CNT_EN
    chk("ovf_cnt1", 64'(ovf_count), 64'h1);
`endif
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0, '0, 1); step();
    end
    chk("ovf_drained_n", 64'(drained.size()), 64'd8);
    for (int i = 0; i < 8 && i < drained.size(); i++)
      chk($sformatf("ovf_w%0d", i), 64'(drained[i]), 64'(i + 1));
    chk("ovf_sticky", 64'(overflow), 64'h1);

    // Simultaneous push and pop while full
    reset_and_run();
    fill(8, 1);
    drive(0, 1, 1, WIDTH'(10), 1); step();
    chk("pp_count", 64'(count), 64'd8);
    chk("pp_ovf", 64'(overflow), 64'h0);
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0, '0, 1); step();
    end
    chk("pp_drained_n", 64'(drained.size()), 64'd9);
    for (int i = 1; i < 8 && i < drained.size(); i++)
      chk($sformatf("pp_w%0d", i), 64'(drained[i]), 64'(i + 1));
    if (drained.size() == 9) chk("pp_last", 64'(drained[8]), 64'd10);

    // Drain: outFlag ignored once enable drops
    reset_and_run();
    fill(3, 20);
    drive(0, 0, 0, '0, 0); step();
    chk("drain_startIO", 64'(startIO), 64'h0);
    drive(0, 0, 1, WIDTH'(36'h77), 0); step();
    chk("drain_ignored", 64'(count), 64'd3);
    chk("drain_noovf", 64'(overflow), 64'h0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, '0, 1); step();
    end
    chk("drain_empty", 64'(empty), 64'h1);
    drive(0, 0, 1, WIDTH'(36'h55), 1); step();
    drive(0, 0, 1, WIDTH'(36'h56), 1); step();
    chk("idle_ignored", 64'(count), 64'd0);
    chk("drain_order", 64'(drained.size()), 64'd3);

    // Backpressure stability
    reset_and_run();
    drive(0, 1, 1, 36'hF_0000_000F, 0); step();
    drive(0, 1, 0, '0, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("bp_dout%0d", i), 64'(dout), 64'hF_0000_000F);
      chk($sformatf("bp_valid%0d", i), 64'(dout_valid), 64'h1);
    end

    // Reset mid-operation with overflow set and count=5
    reset_and_run();
    fill(9, 1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, '0, 1); step();
    end
    chk("mid_count5", 64'(count), 64'd5);
    drive(1, 1, 1, WIDTH'(99), 1); step();
    chk("mid_count", 64'(count), 64'd0);
    chk("mid_empty", 64'(empty), 64'h1);
    chk("mid_startIO", 64'(startIO), 64'h0);
    chk("mid_ovf", 64'(overflow), 64'h0);

    // Random traffic against the model (pointer wrap, mixed states)
    drive(0, 1, 0, '0, 0); step();
    for (int i = 0; i < 400; i++) begin
      drive(0, ($urandom_range(0, 9) != 0), $urandom_range(0, 1) == 1,
            WIDTH'({$urandom, $urandom}), $urandom_range(0, 2) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_out_capture.md
CPU_OUT_CAPTURE -- requirements
Module: cpu_out_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 36, the CPU output word width.
REQ-002 SHALL have parameter DEPTH, default 8, the FIFO depth in words; a power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1 bit: the operator run switch.
REQ-006 SHALL have port startIO, output, 1 bit: the CPU IO start, driven to the CPU startIO.
REQ-007 SHALL have port outFlag, input, 1 bit: the CPU output strobe, one word per high cycle.
REQ-008 SHALL have port out, input, WIDTH bits: the CPU output word, valid when outFlag=1.
REQ-009 SHALL have port dout, output, WIDTH bits: the head-of-FIFO word.
REQ-010 SHALL have port dout_valid, output, 1 bit: dout holds a valid word.
REQ-011 SHALL have port dout_ready, input, 1 bit: the downstream accepts dout.
REQ-012 SHALL have port count, output, $clog2(DEPTH)+1 bits: the FIFO occupancy.
REQ-013 SHALL have port full, output, 1 bit, meaning count==DEPTH.
REQ-014 SHALL have port empty, output, 1 bit, meaning count==0.
REQ-015 SHALL have port overflow, output, 1 bit: sticky, set when a word is dropped.

Function
REQ-016 SHALL implement the FSM states IDLE, RUN and DRAIN, with state registered on clk.
REQ-017 SHALL transition IDLE->RUN when enable=1; RUN->DRAIN when enable=0; DRAIN->IDLE when empty=1; DRAIN->RUN when enable=1.
REQ-018 SHALL drive startIO=1 exactly while state==RUN, as a registered output with no combinational path from enable.
REQ-019 SHALL push out into the FIFO on a clk edge where outFlag=1 and state==RUN and (full=0 or pop occurs the same cycle).
REQ-020 SHALL ignore outFlag in IDLE and DRAIN: no push, no overflow.
REQ-021 SHALL drop the word and set overflow=1 when outFlag=1 in RUN with full=1 and no pop that cycle; FIFO contents remain unchanged.
REQ-022 SHALL pop when dout_valid=1 and dout_ready=1; dout SHALL then show the next word on the following cycle.
REQ-023 SHALL hold dout_valid equal to !empty; dout SHALL be stable while dout_valid=1 and dout_ready=0.
REQ-024 SHALL, on a simultaneous push and pop, leave count unchanged and preserve order; when empty, no pop occurs and the word is pushed.
REQ-025 SHALL provide first-word latency of 1 cycle: a push at edge N gives dout_valid=1 after edge N.
REQ-026 SHALL wrap read and write pointers modulo DEPTH.
REQ-027 SHALL update count by +1 on push-only, -1 on pop-only, and hold it otherwise.
REQ-028 SHALL clear overflow only by reset.

Reset
REQ-029 SHALL, on reset=1 at a clk edge: state=IDLE, startIO=0, pointers=0, count=0, empty=1, full=0, dout_valid=0, overflow=0, and ovf_count=0 if present.
REQ-030 SHALL give reset priority over all push/pop/FSM activity, discarding buffered words mid-operation.
REQ-031 SHALL drive dout to all-zeros while empty.

Configuration
REQ-032 SHALL, with macro CPU_OUT_CAPTURE_OVF_CNT_EN defined, add output ovf_count (16 bits), incremented per dropped word and saturating at 16'hFFFF.
REQ-033 SHALL, without CPU_OUT_CAPTURE_OVF_CNT_EN, omit the ovf_count port and its logic; all other behaviour is identical.

Verification
REQ-034 SHALL cover basic flow: reset, enable=1, outFlag pulses with 36'h0_0000_0001, 36'h9_ABCD_1234 and dout_ready=1 -> startIO=1 one cycle after enable; dout shows the same words in order; empty=1 afterward.
REQ-035 SHALL cover overflow: DEPTH=8, dout_ready=0, 9 consecutive outFlag words 1..9 -> full=1 after 8; word 9 dropped; overflow=1; drained words are 1..8; ovf_count=1 when enabled.
REQ-036 SHALL cover push/pop when full: full with 1..8, outFlag with word 10 and dout_ready=1 in the same cycle -> count stays 8; drain order is 2..8,10; overflow=0.
REQ-037 SHALL cover drain: enable=0 with 3 words buffered -> startIO=0 next cycle; a subsequent outFlag is ignored; state returns to IDLE after the 3rd pop.
REQ-038 SHALL cover backpressure: dout_ready=0 for 5 cycles with dout=36'hF_0000_000F -> dout and dout_valid are stable across all 5 cycles.
REQ-039 SHALL cover reset mid-operation: reset=1 with count=5 in RUN -> next cycle count=0, empty=1, startIO=0, overflow=0.
